// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and the action encoding used by the Gray counter family.
// Conversions take a width argument so one function serves every counter width up to GRAY_MAX_W.
package gray_pkg;

  localparam int GRAY_MAX_W = 32;

  typedef enum logic [1:0] {
    ACT_HOLD = 2'd0,
    ACT_STEP = 2'd1,
    ACT_LOAD = 2'd2,
    ACT_CLR  = 2'd3
  } act_e;

  function automatic logic [GRAY_MAX_W-1:0] width_mask(input int w);
    if (w >= GRAY_MAX_W) return '1;
    return (32'd1 << w) - 32'd1;
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b,
                                                     input int w);
    logic [GRAY_MAX_W-1:0] m;
    m = b & width_mask(w);
    return m ^ (m >> 1);
  endfunction

  // MSB-first prefix XOR; bits above w are masked off so they contribute nothing.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g,
                                                     input int w);
    logic [GRAY_MAX_W-1:0] m;
    logic [GRAY_MAX_W-1:0] b;
    m = g & width_mask(w);
    b = '0;
    b[GRAY_MAX_W-1] = m[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W-2; i >= 0; i--) begin
      b[i] = b[i+1] ^ m[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Purely combinational Gray-to-binary converter for load paths and synchronizer blocks.
module gray2bin_conv
  import gray_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  assign bin = WIDTH'(gray2bin(GRAY_MAX_W'(gray), WIDTH));

endmodule

// File: rtl/gray_updown_counter.sv
// Up/down counter with registered Gray and binary outputs, clear, Gray load and wrap/saturate modes.
// Gray is derived from the next-state binary so both outputs change on the same edge.
module gray_updown_counter
  import gray_pkg::*;
#(
  parameter int          WIDTH    = 4,
  parameter bit          SATURATE = 1'b0,
  parameter int unsigned RST_VAL  = 0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_gray,
  output logic [WIDTH-1:0] gray_out,
  output logic [WIDTH-1:0] bin_out,
  output logic             wrap,
  output logic             at_limit,
  output logic             sat_hit
);

  generate
    if (WIDTH < 2 || WIDTH > GRAY_MAX_W) begin : g_bad_width
      $error("gray_updown_counter: WIDTH must be in 2..32");
    end
    if (WIDTH < GRAY_MAX_W && ((64'(RST_VAL) >> WIDTH) != 64'd0)) begin : g_bad_rst
      $error("gray_updown_counter: RST_VAL does not fit in WIDTH bits");
    end
  endgenerate

  localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RST_VAL);
  localparam logic [WIDTH-1:0] RST_GRAY = WIDTH'(bin2gray(GRAY_MAX_W'(RST_BIN), WIDTH));
  localparam logic [WIDTH-1:0] MAX_BIN  = '1;

  typedef struct packed {
    logic [WIDTH-1:0] bin;
    logic             wrap;
    logic             sat;
  } step_t;

  // At a limit the step either wraps (SATURATE=0) or is blocked (SATURATE=1).
  function automatic step_t step_count(input logic [WIDTH-1:0] cur, input logic dir_up);
    step_t s;
    s.bin  = cur;
    s.wrap = 1'b0;
    s.sat  = 1'b0;
    if (dir_up) begin
      if (cur != MAX_BIN) begin
        s.bin = cur + WIDTH'(1);
      end else if (SATURATE) begin
        s.sat = 1'b1;
      end else begin
        s.bin  = '0;
        s.wrap = 1'b1;
      end
    end else begin
      if (cur != '0) begin
        s.bin = cur - WIDTH'(1);
      end else if (SATURATE) begin
        s.sat = 1'b1;
      end else begin
        s.bin  = MAX_BIN;
        s.wrap = 1'b1;
      end
    end
    return s;
  endfunction

  act_e             act;
  logic [WIDTH-1:0] load_bin;
  step_t            step_p0;
  logic [WIDTH-1:0] bin_p0;
  logic [WIDTH-1:0] gray_p0;
  logic             wrap_p0;
  logic             sat_p0;
  logic [WIDTH-1:0] bin_p1;
  logic [WIDTH-1:0] gray_p1;
  logic             wrap_p1;
  logic             sat_p1;

  gray2bin_conv #(.WIDTH(WIDTH)) u_load_conv (
    .gray (load_gray),
    .bin  (load_bin)
  );

  always_comb begin
    act = ACT_HOLD;
    if (clr)       act = ACT_CLR;
    else if (load) act = ACT_LOAD;
    else if (en)   act = ACT_STEP;
  end

  // Stage p0: next-state selection from the current registered count.
  always_comb begin
    step_p0 = step_count(bin_p1, up);
    bin_p0  = bin_p1;
    wrap_p0 = 1'b0;
    sat_p0  = 1'b0;
    unique case (act)
      ACT_CLR:  bin_p0 = RST_BIN;
      ACT_LOAD: bin_p0 = load_bin;
      ACT_STEP: begin
        bin_p0  = step_p0.bin;
        wrap_p0 = step_p0.wrap;
        sat_p0  = step_p0.sat;
      end
      default:  bin_p0 = bin_p1;
    endcase
    gray_p0 = WIDTH'(bin2gray(GRAY_MAX_W'(bin_p0), WIDTH));
  end

  // Stage p1: registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bin_p1  <= RST_BIN;
      gray_p1 <= RST_GRAY;
      wrap_p1 <= 1'b0;
      sat_p1  <= 1'b0;
    end else begin
      bin_p1  <= bin_p0;
      gray_p1 <= gray_p0;
      wrap_p1 <= wrap_p0;
      sat_p1  <= sat_p0;
    end
  end

  assign bin_out  = bin_p1;
  assign gray_out = gray_p1;
  assign wrap     = wrap_p1;
  assign sat_hit  = sat_p1;
  assign at_limit = up ? (bin_p1 == MAX_BIN) : (bin_p1 == '0);

endmodule

// File: tb/tb_gray_updown_counter.sv
// Directed bench: a wrapping counter (RST_VAL=0) and a saturating counter (RST_VAL=5).
module tb_gray_updown_counter;

  logic       clk = 1'b0;
  logic       rstn;
  logic       en_a, up_a, clr_a, load_a;
  logic [3:0] load_gray_a, gray_a, bin_a;
  logic       wrap_a, at_limit_a, sat_a;
  logic       en_b, up_b, clr_b, load_b;
  logic [3:0] load_gray_b, gray_b, bin_b;
  logic       wrap_b, at_limit_b, sat_b;

  int checks = 0;
  int passed = 0;

  logic [3:0] gray_tbl [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                                4'b0110, 4'b0111, 4'b0101, 4'b0100,
                                4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                4'b1010, 4'b1011, 4'b1001, 4'b1000};

  always #5 clk = ~clk;

  gray_updown_counter #(.WIDTH(4), .SATURATE(1'b0), .RST_VAL(0)) u_a (
    .clk(clk), .rstn(rstn), .en(en_a), .up(up_a), .clr(clr_a), .load(load_a),
    .load_gray(load_gray_a), .gray_out(gray_a), .bin_out(bin_a),
    .wrap(wrap_a), .at_limit(at_limit_a), .sat_hit(sat_a)
  );

  gray_updown_counter #(.WIDTH(4), .SATURATE(1'b1), .RST_VAL(5)) u_b (
    .clk(clk), .rstn(rstn), .en(en_b), .up(up_b), .clr(clr_b), .load(load_b),
    .load_gray(load_gray_b), .gray_out(gray_b), .bin_out(bin_b),
    .wrap(wrap_b), .at_limit(at_limit_b), .sat_hit(sat_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    en_a = 0; up_a = 1; clr_a = 0; load_a = 0; load_gray_a = '0;
    en_b = 0; up_b = 1; clr_b = 0; load_b = 0; load_gray_b = '0;
    tick(); tick();
    checks++; if (bin_a !== 4'd0) $display("FAIL reset_bin_a got %h want 0", bin_a); else passed++;
    checks++; if (gray_a !== 4'b0000) $display("FAIL reset_gray_a got %b want 0000", gray_a); else passed++;
    checks++; if (wrap_a !== 1'b0) $display("FAIL reset_wrap_a got %b want 0", wrap_a); else passed++;
    checks++; if (bin_b !== 4'd5) $display("FAIL reset_bin_b got %h want 5", bin_b); else passed++;
    checks++; if (gray_b !== 4'b0111) $display("FAIL reset_gray_b got %b want 0111", gray_b); else passed++;
    checks++; if (sat_b !== 1'b0) $display("FAIL reset_sat_b got %b want 0", sat_b); else passed++;
    #3 rstn = 1'b1;
  endtask

  task automatic test_count_up();
    logic [3:0] prev;
    logic [3:0] exp_bin;
    logic       exp_wrap;
    en_a = 1; up_a = 1;
    for (int i = 0; i < 16; i++) begin
      prev = gray_a;
      tick();
      exp_bin  = 4'(i + 1);
      exp_wrap = (i == 15);
      checks++; if (gray_a !== gray_tbl[exp_bin]) $display("FAIL up_gray step %0d got %b want %b", i, gray_a, gray_tbl[exp_bin]); else passed++;
      checks++; if (bin_a !== exp_bin) $display("FAIL up_bin step %0d got %h want %h", i, bin_a, exp_bin); else passed++;
      checks++; if ($countones(gray_a ^ prev) != 1) $display("FAIL up_onebit step %0d got %b from %b", i, gray_a, prev); else passed++;
      checks++; if (wrap_a !== exp_wrap) $display("FAIL up_wrap step %0d got %b want %b", i, wrap_a, exp_wrap); else passed++;
    end
    en_a = 0;
    tick();
    checks++; if (wrap_a !== 1'b0) $display("FAIL wrap_single_cycle got %b want 0", wrap_a); else passed++;
    checks++; if (bin_a !== 4'd0) $display("FAIL hold_bin got %h want 0", bin_a); else passed++;
  endtask

  task automatic test_down_wrap();
    up_a = 0;
    #1;
    checks++; if (at_limit_a !== 1'b1) $display("FAIL down_at_limit_before got %b want 1", at_limit_a); else passed++;
    en_a = 1;
    tick();
    en_a = 0;
    checks++; if (bin_a !== 4'd15) $display("FAIL down_bin got %h want f", bin_a); else passed++;
    checks++; if (gray_a !== 4'b1000) $display("FAIL down_gray got %b want 1000", gray_a); else passed++;
    checks++; if (wrap_a !== 1'b1) $display("FAIL down_wrap got %b want 1", wrap_a); else passed++;
    checks++; if (at_limit_a !== 1'b0) $display("FAIL down_at_limit_after got %b want 0", at_limit_a); else passed++;
  endtask

  task automatic test_load();
    load_a = 1; load_gray_a = 4'b1101; en_a = 1; up_a = 0;
    tick();
    load_a = 0; up_a = 1;
    checks++; if (bin_a !== 4'd9) $display("FAIL load_bin got %h want 9", bin_a); else passed++;
    checks++; if (gray_a !== 4'b1101) $display("FAIL load_gray got %b want 1101", gray_a); else passed++;
    checks++; if (wrap_a !== 1'b0) $display("FAIL load_wrap got %b want 0", wrap_a); else passed++;
    tick();
    en_a = 0;
    checks++; if (bin_a !== 4'd10) $display("FAIL load_step_bin got %h want a", bin_a); else passed++;
    checks++; if (gray_a !== 4'b1111) $display("FAIL load_step_gray got %b want 1111", gray_a); else passed++;
  endtask

  task automatic test_priority();
    load_b = 1; load_gray_b = 4'b0000;
    tick();
    checks++; if (bin_b !== 4'd0) $display("FAIL prio_preload_bin got %h want 0", bin_b); else passed++;
    clr_b = 1; load_b = 1; load_gray_b = 4'b1101; en_b = 1; up_b = 0;
    tick();
    clr_b = 0;
    checks++; if (bin_b !== 4'd5) $display("FAIL prio_clr_bin got %h want 5", bin_b); else passed++;
    checks++; if (gray_b !== 4'b0111) $display("FAIL prio_clr_gray got %b want 0111", gray_b); else passed++;
    checks++; if (wrap_b !== 1'b0) $display("FAIL prio_clr_wrap got %b want 0", wrap_b); else passed++;
    checks++; if (sat_b !== 1'b0) $display("FAIL prio_clr_sat got %b want 0", sat_b); else passed++;
    load_gray_b = 4'b1000; up_b = 1;
    tick();
    load_b = 0; en_b = 0;
    checks++; if (bin_b !== 4'd15) $display("FAIL prio_load_over_en got %h want f", bin_b); else passed++;
  endtask

  task automatic test_saturate();
    en_b = 1; up_b = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bin_b !== 4'd15) $display("FAIL sat_bin cycle %0d got %h want f", i, bin_b); else passed++;
      checks++; if (gray_b !== 4'b1000) $display("FAIL sat_gray cycle %0d got %b want 1000", i, gray_b); else passed++;
      checks++; if (sat_b !== 1'b1) $display("FAIL sat_hit cycle %0d got %b want 1", i, sat_b); else passed++;
      checks++; if (wrap_b !== 1'b0) $display("FAIL sat_wrap cycle %0d got %b want 0", i, wrap_b); else passed++;
    end
    checks++; if (at_limit_b !== 1'b1) $display("FAIL sat_at_limit got %b want 1", at_limit_b); else passed++;
    en_b = 0;
    tick();
    checks++; if (sat_b !== 1'b0) $display("FAIL sat_idle got %b want 0", sat_b); else passed++;
    load_b = 1; load_gray_b = 4'b0000;
    tick();
    load_b = 0; en_b = 1; up_b = 0;
    tick();
    en_b = 0;
    checks++; if (bin_b !== 4'd0) $display("FAIL sat_down_bin got %h want 0", bin_b); else passed++;
    checks++; if (sat_b !== 1'b1) $display("FAIL sat_down_hit got %b want 1", sat_b); else passed++;
  endtask

  task automatic test_async_reset();
    load_a = 1; load_gray_a = 4'b0100;
    tick();
    load_a = 0; en_a = 1; up_a = 1;
    checks++; if (bin_a !== 4'd7) $display("FAIL arst_pre_bin got %h want 7", bin_a); else passed++;
    #3 rstn = 1'b0;
    #1;
    checks++; if (bin_a !== 4'd0) $display("FAIL arst_now_bin_a got %h want 0", bin_a); else passed++;
    checks++; if (gray_a !== 4'b0000) $display("FAIL arst_now_gray_a got %b want 0000", gray_a); else passed++;
    checks++; if (bin_b !== 4'd5) $display("FAIL arst_now_bin_b got %h want 5", bin_b); else passed++;
    tick();
    checks++; if (bin_a !== 4'd0) $display("FAIL arst_held_bin_a got %h want 0", bin_a); else passed++;
    checks++; if (gray_b !== 4'b0111) $display("FAIL arst_held_gray_b got %b want 0111", gray_b); else passed++;
    #3 rstn = 1'b1;
    tick();
    en_a = 0;
    checks++; if (bin_a !== 4'd1) $display("FAIL arst_first_step got %h want 1", bin_a); else passed++;
    checks++; if (gray_a !== 4'b0001) $display("FAIL arst_first_gray got %b want 0001", gray_a); else passed++;
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_down_wrap();
    test_load();
    test_priority();
    test_saturate();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout got %0d checks want completion", checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/gray_updown_counter.md
Name: gray_updown_counter

Overview:
- Parametrised successor to the fixed 4-bit binary-to-Gray counter.
- Configurable width; up/down counting; count enable; synchronous clear; synchronous load of a Gray-coded value; wrap or saturate mode.
- Gray output is registered, so it is glitch-free for clock-domain-crossing pointers and position encoders.
- Companion binary output and event flags serve local control logic.

Parameters:
- WIDTH, 4, counter width in bits (legal 2..32).
- SATURATE, 0, 0 = wrap at limits, 1 = hold at limits.
- RST_VAL, 0, binary reset/clear value (must be < 2**WIDTH).

Ports:
- clk  input  1  rising-edge clock
- rstn  input  1  asynchronous active-low reset
- en  input  1  count enable; one step per cycle while high
- up  input  1  direction: 1 = increment, 0 = decrement; sampled only when en=1
- clr  input  1  synchronous clear to RST_VAL
- load  input  1  synchronous load
- load_gray  input  WIDTH  Gray-coded load value
- gray_out  output  WIDTH  registered Gray code of the current count
- bin_out  output  WIDTH  registered binary count
- wrap  output  1  one-cycle pulse: the previous step wrapped
- at_limit  output  1  count equals the limit in the current up direction
- sat_hit  output  1  one-cycle pulse: a step was blocked at a limit (SATURATE=1 only)

Behaviour:
- Reset (rstn low, asynchronous):
  - bin_out = RST_VAL, gray_out = bin2gray(RST_VAL).
  - wrap = 0, sat_hit = 0.
  - Reset release is synchronous to clk; the first count step can occur on the first rising edge with rstn high.
- Priority per rising edge is clr > load > en. Lower-priority requests in the same cycle are ignored, and wrap and sat_hit stay 0 that cycle.
- clr: bin_out <= RST_VAL, gray_out <= bin2gray(RST_VAL).
- load:
  - bin_out <= gray2bin(load_gray); gray_out <= load_gray.
  - Latency is 1 cycle.
  - No wrap or saturate flag is generated.
- en with up=1:
  - If count < 2**WIDTH-1: count + 1.
  - Else if SATURATE=0: count becomes 0 and wrap pulses the next cycle.
  - Else: count holds and sat_hit pulses the next cycle.
- en with up=0:
  - If count > 0: count - 1.
  - Else if SATURATE=0: count becomes 2**WIDTH-1 and wrap pulses.
  - Else: count holds and sat_hit pulses.
- en=0 with no clr/load: all state holds; wrap and sat_hit are 0.
- Output coherence:
  - gray_out and bin_out update on the same edge.
  - gray_out always equals bin2gray(bin_out); no cycle of skew between them.
  - gray_out is computed from the next-state binary and then registered. It is not combinational from bin_out.
- Gray property: on every en step, including a wrap, gray_out changes in exactly one bit. clr and load may change several bits.
- at_limit is combinational from registers and up:
  - up=1: (bin_out == all ones).
  - up=0: (bin_out == 0).
- Width arithmetic: all counting is modulo 2**WIDTH, with no carry-out port. The conversions are:
  - bin2gray(b) = b ^ (b >> 1).
  - gray2bin is an MSB-first prefix XOR.
- Illegal parameters (WIDTH < 2, or RST_VAL out of range) trigger an elaboration-time assertion.

Decomposition:
- Package gray_pkg holds:
  - function bin2gray(logic [WIDTH-1:0]) and function gray2bin, parametrised via a let or a width argument pattern with a max width of 32.
  - localparam GRAY_MAX_W = 32.
- One sub-module, gray2bin_conv #(WIDTH): purely combinational load-path converter, reusable by future synchronizer blocks.
- The counter core, next-state mux and flag registers live in gray_updown_counter.

Test Plan:
- Reset and step: WIDTH=4, RST_VAL=0, rstn low then high, en=1, up=1 for 16 cycles.
  - Expect gray_out sequence 0000,0001,0011,0010,0110,...,1000, then 0000.
  - Expect wrap high exactly one cycle after the 1000->0000 step.
  - Expect a single-bit change on every step.
- Down wrap: bin_out=0, en=1, up=0.
  - Expect bin_out=15, gray_out=1000, wrap pulse.
  - Expect at_limit=1 before the step and 0 after.
- Load: load=1, load_gray=4'b1101.
  - Expect bin_out=9 and gray_out=1101 next cycle, with no wrap.
  - Then en=1, up=1: expect bin_out=10, gray_out=1111.
- Priority: clr=1, load=1, en=1 with RST_VAL=5.
  - Expect bin_out=5, gray_out=0111, wrap=0, sat_hit=0.
- Saturate: SATURATE=1, load 1000 (bin 15), en=1, up=1 for 3 cycles.
  - Expect bin_out held at 15, sat_hit high each following cycle, wrap never high.
- Async reset mid-count: assert rstn low between edges at bin_out=7.
  - Expect outputs at RST_VAL immediately, before the next clk edge, and held while rstn is low.
